hash_key_loader: RTL and testbench
==================================

Name: hash_key_loader

Overview:
- Front end for the Jenkins hash pipeline. Takes a memcache key as a byte stream from the protocol parser, with the key length from the header.
- Packs bytes little-endian into 12-byte blocks (k0, k1, k2).
- Presents each block with its remaining-length tag, the same semantics as the hash round word counter, to the hash core.
- Checks the byte stream against the header length and flags mismatches.

Parameters:
MAX_KEY_LEN, 250, largest legal key length in bytes (memcache limit); must be ≤255.

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
len_valid  input  1  header key length available
len_ready  output  1  loader idle and accepting a new key length
len_in  input  8  key length in bytes from memcache header
in_valid  input  1  key byte valid
in_ready  output  1  loader accepting key bytes
in_data  input  8  key byte, first byte of key first
in_last  input  1  marks final byte of key
out_valid  output  1  block valid toward hash core
out_ready  input  1  hash core accepts block
k0  output  32  key bytes 0-3 of block, byte0 in [7:0]
k1  output  32  key bytes 4-7 of block
k2  output  32  key bytes 8-11 of block
out_rem  output  8  bytes remaining in key from start of this block
out_first  output  1  block is first of key
out_last  output  1  block is final of key
key_length  output  8  latched header length, stable from len accept until next len accept
err  output  1  one-cycle pulse on length/framing error

Behaviour:
- One clock, CLK; reset RST is synchronous and active-high.
- Reset values:
  - out_valid, err, out_first, out_last = 0.
  - k0/k1/k2, out_rem, key_length = 0.
  - FSM enters IDLE.
  - len_ready and in_ready are 0 while RST is high.
- FSM states: IDLE, FILL, EMIT, DRAIN.
- IDLE:
  - len_ready = 1 and in_ready = 0.
  - On len_valid:
    - latch key_length = len_in, rem = len_in, first = 1, clear the block to zero, byte index j = 0.
    - If len_in > MAX_KEY_LEN: pulse err next cycle, go to DRAIN.
    - Else if len_in == 0: go to EMIT with an all-zero block, out_rem = 0, out_last = 1.
    - Else: go to FILL.
- FILL:
  - in_ready = 1.
  - Each accepted byte writes lane j: word j/4, bits [(j%4)*8+7 : (j%4)*8]. Then j increments and the total byte count increments.
  - Block complete when j reaches 12 or total count reaches key_length; go to EMIT on the following edge.
  - out_rem = rem; out_last = (rem ≤ 12).
  - Unwritten lanes stay 0.
- Framing checks in FILL:
  - in_last on a byte with count < key_length: pulse err, discard the partial block (no out_valid), go to IDLE.
  - Byte that makes count == key_length without in_last: pulse err, discard the block, go to DRAIN.
- EMIT:
  - out_valid = 1 and in_ready = 0.
  - k0/k1/k2, out_rem, out_first, out_last stay stable until out_valid && out_ready.
  - On accept:
    - If out_last: go to IDLE.
    - Else: rem = rem − 12, first = 0, block cleared, j = 0, go to FILL.
- DRAIN:
  - in_ready = 1; bytes are discarded.
  - On an accepted byte with in_last: go to IDLE.
- Latency:
  - out_valid rises the cycle after the last byte of a block is accepted.
  - Throughput is at most 12 bytes per 13 cycles, plus any out_ready stall.
- Widths:
  - rem and count are 8-bit; rem − 12 is only taken when rem > 12, so no wrap.
  - out_rem sequence for length L: L, L−12, L−24, …, final value in 1..12, or 0 for L = 0.
- Simultaneous events:
  - len_valid is ignored outside IDLE.
  - in_valid is ignored in IDLE and EMIT.
  - err and out_valid are never high in the same cycle.
- RST mid-key: the partial block is dropped with no err and no out_valid; normal behaviour resumes the cycle after RST deasserts.

Test Plan:
- len_in = 5, bytes "hello" (in_last on 'o'):
  - one block k0 = 0x6c6c6568, k1 = 0x0000006f, k2 = 0;
  - out_rem = 5, first = 1, last = 1; err = 0.
- len_in = 12, bytes 0x00..0x0b:
  - k0 = 0x03020100, k1 = 0x07060504, k2 = 0x0b0a0908;
  - out_rem = 12, first = last = 1.
- len_in = 13, bytes 0x00..0x0c:
  - block 1: out_rem = 13, first = 1, last = 0;
  - block 2: k0 = 0x0000000c, k1 = k2 = 0, out_rem = 1, first = 0, last = 1.
- Backpressure in the 13-byte case, out_ready low 5 cycles in each EMIT:
  - outputs held stable, in_ready = 0, no byte lost;
  - key_length = 13 throughout.
- len_in = 8 with in_last on byte 3:
  - err pulses one cycle, no out_valid, len_ready = 1 the following cycle.
- len_in = 0: single block of zeros, out_rem = 0, first = last = 1, no bytes consumed.
- len_in = 251, then 4 bytes with in_last on the 4th:
  - err pulses once, all 4 bytes accepted and discarded, returns to IDLE.
- Reset asserted mid-FILL: outputs return to reset values, no err; a following 5-byte key hashes correctly.

Source files
------------

// File: rtl/hash_key_loader.sv
// Key loader for the Jenkins hash pipeline: packs a byte-serial memcache key into
// 12-byte little-endian blocks tagged with the bytes remaining, and checks framing.
module hash_key_loader #(
  parameter int unsigned MAX_KEY_LEN = 250
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        len_valid,
  output logic        len_ready,
  input  logic [7:0]  len_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] k0,
  output logic [31:0] k1,
  output logic [31:0] k2,
  output logic [7:0]  out_rem,
  output logic        out_first,
  output logic        out_last,
  output logic [7:0]  key_length,
  output logic        err
);

  localparam logic [7:0] MAX_LEN   = 8'(MAX_KEY_LEN);
  localparam logic [7:0] BLK_BYTES = 8'd12;

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DRAIN} state_t;

  state_t      state, next_state;
  logic [95:0] blk;
  logic [7:0]  rem;
  logic [7:0]  count;
  logic [7:0]  key_len_q;
  logic [3:0]  lane;
  logic        first_q;
  logic        last_q;
  logic        err_q;

  logic        len_fire;
  logic        byte_fire;
  logic        blk_accept;
  logic        err_set;
  logic [7:0]  count_nxt;
  logic [7:0]  rem_nxt;
  logic        at_len;

  assign count_nxt = count + 8'd1;
  assign rem_nxt   = rem - BLK_BYTES;
  assign at_len    = (count_nxt == key_len_q);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    next_state = state;
    len_ready  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        len_ready = 1'b1;
        if (len_valid) begin
          if (len_in > MAX_LEN) begin
            err_set    = 1'b1;
            next_state = DRAIN;
          end else if (len_in == 8'd0) begin
            next_state = EMIT;
          end else begin
            next_state = FILL;
          end
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Early in_last returns to IDLE; a missing in_last must drain to the real end.
          if (in_last && !at_len) begin
            err_set    = 1'b1;
            next_state = IDLE;
          end else if (at_len && !in_last) begin
            err_set    = 1'b1;
            next_state = DRAIN;
          end else if (at_len || lane == 4'd11) begin
            next_state = EMIT;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = last_q ? IDLE : FILL;
      end
      DRAIN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (RST) begin
      len_ready  = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      err_set    = 1'b0;
      next_state = IDLE;
    end
  end

  assign len_fire   = len_ready && len_valid;
  assign byte_fire  = in_ready && in_valid && (state == FILL);
  assign blk_accept = out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      blk       <= '0;
      rem       <= '0;
      count     <= '0;
      key_len_q <= '0;
      lane      <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge view.
      err_q <= err_set;
      if (len_fire) begin
        key_len_q <= len_in;
        rem       <= len_in;
        first_q   <= 1'b1;
        last_q    <= (len_in <= BLK_BYTES);
        blk       <= '0;
        lane      <= '0;
        count     <= '0;
      end
      if (byte_fire) begin
        blk[{lane, 3'b000} +: 8] <= in_data;
        lane                     <= lane + 4'd1;
        count                    <= count_nxt;
      end
      if (blk_accept && !last_q) begin
        rem     <= rem_nxt;
        first_q <= 1'b0;
        last_q  <= (rem_nxt <= BLK_BYTES);
        blk     <= '0;
        lane    <= '0;
      end
    end
  end

  assign k0         = blk[31:0];
  assign k1         = blk[63:32];
  assign k2         = blk[95:64];
  assign out_rem    = rem;
  assign out_first  = first_q;
  assign out_last   = last_q;
  assign key_length = key_len_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hash_key_loader.sv
// Directed bench for hash_key_loader: block packing, remaining-length tags,
// backpressure, framing errors, oversize keys and mid-key reset.
module tb_hash_key_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        len_valid = 1'b0;
  logic        len_ready;
  logic [7:0]  len_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] k0, k1, k2;
  logic [7:0]  out_rem;
  logic        out_first, out_last;
  logic [7:0]  key_length;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int ov_cnt   = 0;
  int both_cnt = 0;

  hash_key_loader #(.MAX_KEY_LEN(250)) dut (
    .CLK(CLK), .RST(RST),
    .len_valid(len_valid), .len_ready(len_ready), .len_in(len_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .k0(k0), .k1(k1), .k2(k2),
    .out_rem(out_rem), .out_first(out_first), .out_last(out_last),
    .key_length(key_length), .err(err)
  );

  always #5 CLK = ~CLK;

  // Pulse monitors, sampled shortly after each rising edge.
  always begin
    @(posedge CLK);
    #2;
    if (err === 1'b1)                          err_cnt++;
    if (out_valid === 1'b1)                    ov_cnt++;
    if (err === 1'b1 && out_valid === 1'b1)    both_cnt++;
  end

  // {k0,k1,k2,out_rem,out_first,out_last}
  function automatic logic [105:0] blk_obs();
    return {k0, k1, k2, out_rem, out_first, out_last};
  endfunction

  task automatic send_len(input logic [7:0] l);
    int n = 0;
    while (len_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    if (len_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL len_timeout len_ready=%b required=1", len_ready);
    end else begin
      len_valid = 1'b1; len_in = l;
      @(negedge CLK);
      len_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = b; in_last = last;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL byte_timeout in_ready=%b required=1", in_ready);
    end else begin
      @(negedge CLK);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (out_valid !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
  endtask

  task automatic accept_block();
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({len_ready, in_ready, out_valid, err, out_first, out_last} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b required=000000",
               {len_ready, in_ready, out_valid, err, out_first, out_last});
    end
    checks++;
    if ({k0, k1, k2, out_rem, key_length} !== 112'h0) begin
      failures++;
      $display("FAIL reset_data got=%h required=0", {k0, k1, k2, out_rem, key_length});
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({len_ready, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_idle got=%b required=10", {len_ready, in_ready});
    end
  endtask

  task automatic test_hello();
    logic [105:0] exp_b;
    logic [7:0]   msg [5];
    int           e0 = err_cnt;
    msg = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
    send_len(8'd5);
    for (int i = 0; i < 5; i++) send_byte(msg[i], i == 4);
    wait_valid();
    exp_b = {32'h6c6c6568, 32'h0000006f, 32'h0, 8'd5, 1'b1, 1'b1};
    checks++;
    if (out_valid !== 1'b1 || blk_obs() !== exp_b) begin
      failures++;
      $display("FAIL hello_block valid=%b got=%h required=%h", out_valid, blk_obs(), exp_b);
    end
    accept_block();
    checks++;
    if (err_cnt != e0 || len_ready !== 1'b1) begin
      failures++;
      $display("FAIL hello_done err_pulses=%0d len_ready=%b required 0 and 1",
               err_cnt - e0, len_ready);
    end
  endtask

  task automatic test_len12();
    logic [105:0] exp_b;
    send_len(8'd12);
    for (int i = 0; i < 12; i++) send_byte(8'(i), i == 11);
    wait_valid();
    exp_b = {32'h03020100, 32'h07060504, 32'h0b0a0908, 8'd12, 1'b1, 1'b1};
    checks++;
    if (out_valid !== 1'b1 || blk_obs() !== exp_b) begin
      failures++;
      $display("FAIL len12_block valid=%b got=%h required=%h", out_valid, blk_obs(), exp_b);
    end
    accept_block();
  endtask

  task automatic test_back_to_back();
    logic [105:0] exp_b1, exp_b2;
    int bad;
    exp_b1 = {32'h03020100, 32'h07060504, 32'h0b0a0908, 8'd13, 1'b1, 1'b0};
    exp_b2 = {32'h0000000c, 32'h0, 32'h0, 8'd1, 1'b0, 1'b1};
    send_len(8'd13);
    for (int i = 0; i < 12; i++) send_byte(8'(i), 1'b0);
    wait_valid();
    checks++;
    if (out_valid !== 1'b1 || blk_obs() !== exp_b1) begin
      failures++;
      $display("FAIL b2b_block1 valid=%b got=%h required=%h", out_valid, blk_obs(), exp_b1);
    end
    // Present the final byte during the stall; it must wait for the block to drain.
    in_valid = 1'b1; in_data = 8'h0c; in_last = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || blk_obs() !== exp_b1 ||
          key_length !== 8'd13) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_stall1 bad_cycles=%0d required=0", bad);
    end
    accept_block();
    @(negedge CLK);
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || blk_obs() !== exp_b2) begin
      failures++;
      $display("FAIL b2b_block2 valid=%b got=%h required=%h", out_valid, blk_obs(), exp_b2);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || blk_obs() !== exp_b2 ||
          key_length !== 8'd13) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_stall2 bad_cycles=%0d required=0", bad);
    end
    accept_block();
    checks++;
    if (len_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done len_ready=%b out_valid=%b required 1 and 0", len_ready, out_valid);
    end
  endtask

  task automatic test_short_last();
    int o0 = ov_cnt;
    send_len(8'd8);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43, 1'b1);
    checks++;
    if ({err, out_valid, len_ready} !== 3'b101) begin
      failures++;
      $display("FAIL short_err got err/valid/len_ready=%b required=101", {err, out_valid, len_ready});
    end
    @(negedge CLK);
    checks++;
    if (err !== 1'b0 || ov_cnt != o0) begin
      failures++;
      $display("FAIL short_pulse err=%b valid_cycles=%0d required 0 and 0", err, ov_cnt - o0);
    end
  endtask

  task automatic test_zero();
    logic [105:0] exp_b;
    exp_b = {32'h0, 32'h0, 32'h0, 8'd0, 1'b1, 1'b1};
    send_len(8'd0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || blk_obs() !== exp_b) begin
      failures++;
      $display("FAIL zero_block valid=%b in_ready=%b got=%h required=%h",
               out_valid, in_ready, blk_obs(), exp_b);
    end
    accept_block();
    checks++;
    if (len_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_done len_ready=%b required=1", len_ready);
    end
  endtask

  task automatic test_oversize();
    int e0 = err_cnt;
    int o0 = ov_cnt;
    send_len(8'd251);
    checks++;
    if ({err, len_ready, in_ready} !== 3'b101) begin
      failures++;
      $display("FAIL over_err got err/len_ready/in_ready=%b required=101", {err, len_ready, in_ready});
    end
    for (int i = 0; i < 4; i++) send_byte(8'(8'h80 + i), i == 3);
    checks++;
    if (len_ready !== 1'b1 || err_cnt - e0 != 1 || ov_cnt != o0) begin
      failures++;
      $display("FAIL over_drain len_ready=%b err_pulses=%0d valid_cycles=%0d required 1, 1, 0",
               len_ready, err_cnt - e0, ov_cnt - o0);
    end
  endtask

  task automatic test_reset_mid_fill();
    int e0;
    send_len(8'd250);
    checks++;
    if ({err, len_ready, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL max_len got err/len_ready/in_ready=%b required=001", {err, len_ready, in_ready});
    end
    for (int i = 0; i < 3; i++) send_byte(8'(8'h51 + i), 1'b0);
    e0 = err_cnt;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({len_ready, in_ready, out_valid, err} !== 4'b0 || {k0, k1, k2, out_rem, key_length} !== 112'h0) begin
      failures++;
      $display("FAIL mid_reset ctrl=%b data=%h required 0 and 0",
               {len_ready, in_ready, out_valid, err}, {k0, k1, k2, out_rem, key_length});
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (err_cnt != e0) begin
      failures++;
      $display("FAIL mid_reset_err pulses=%0d required=0", err_cnt - e0);
    end
    test_hello();
  endtask

  initial begin
    test_reset();
    test_hello();
    test_len12();
    test_back_to_back();
    test_short_last();
    test_zero();
    test_oversize();
    test_reset_mid_fill();
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL err_with_valid cycles=%0d required=0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached required=finish");
    $fatal(1, "timeout");
  end

endmodule
